// File: rtl/quat_mul_issue.sv
// Issue/collect wrapper around the pipelined quaternion multiplier, plus its result FIFO.
// Latency: out_valid rises MUL_LATENCY+1 edges after the accepting edge; 1 op/cycle sustained.
// Backpressure: credits cap in-flight plus buffered ops at RDEPTH, so an out_ready stall closes in_ready.

// Generic first-word-fall-through FIFO with natural-wrap pointers one bit wider than the address.
// Latency: a write is visible on rd_dat/empty after the writing edge.
// Backpressure: none internally; the caller guarantees no write when full and no read when empty.
module issue_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    assign empty  = (wr_ptr == rd_ptr);
    assign rd_dat = mem[rd_ptr[AW-1:0]];
endmodule

module quat_mul_issue #(
    parameter int MUL_LATENCY = 4,
    parameter int RDEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_b,
    input  logic [63:0] in_x,
    output logic [63:0] mul_b,
    output logic [63:0] mul_x,
    input  logic [63:0] mul_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_y,
    output logic        busy
);
    localparam int CW = $clog2(RDEPTH + 1);

    logic                 accept;
    logic                 pop;
    logic                 fifo_empty;
    logic [CW-1:0]        credit_cnt;
    logic [MUL_LATENCY:0] vld_sr;

    // in_ready depends on the credit register only, never on out_ready.
    assign in_ready  = (credit_cnt < CW'(RDEPTH));
    assign accept    = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign busy      = (credit_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_b      <= '0;
            mul_x      <= '0;
            vld_sr     <= '0;
            credit_cnt <= '0;
        end else begin
            vld_sr <= {vld_sr[MUL_LATENCY-1:0], accept};
            if (accept) begin
                mul_b <= in_b;
                mul_x <= in_x;
            end
            if (accept && !pop) begin
                credit_cnt <= credit_cnt + CW'(1);
            end else if (!accept && pop) begin
                credit_cnt <= credit_cnt - CW'(1);
            end
        end
    end

    // Tags are cleared by reset, so stale multiplier output after a reset is never written.
    issue_fifo #(
        .WIDTH (64),
        .DEPTH (RDEPTH)
    ) u_rfifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (vld_sr[MUL_LATENCY]),
        .wr_dat (mul_y),
        .rd_en  (pop),
        .rd_dat (out_y),
        .empty  (fifo_empty)
    );
endmodule

// File: tb/tb_quat_mul_issue.sv
// Directed bench for quat_mul_issue with a lane-add stand-in for the multiplier.
module tb_quat_mul_issue;
    localparam int LAT = 4;
    localparam int DEP = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_b      = '0;
    logic [63:0] in_x      = '0;
    logic [63:0] mul_b, mul_x, mul_y, out_y;
    logic        in_ready, out_valid, busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          acc_cnt  = 0;
    int          w;
    int          span;
    logic        seen_vld;
    logic [63:0] pop_q [$];
    int          pop_cyc [$];
    logic [63:0] stg [LAT];
    logic [3:0]  occ;

    always #5 clk = ~clk;

    quat_mul_issue #(.MUL_LATENCY(LAT), .RDEPTH(DEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_b      (in_b),
        .in_x      (in_x),
        .mul_b     (mul_b),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    function automatic logic [63:0] lane_add(input logic [63:0] b, input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[16*i +: 16] = b[16*i +: 16] + x[16*i +: 16];
        end
        return r;
    endfunction

    // Unreset multiplier stand-in: keeps shifting whatever sits on mul_b/mul_x.
    always @(posedge clk) begin
        stg[0] <= lane_add(mul_b, mul_x);
        for (int k = 1; k < LAT; k++) begin
            stg[k] <= stg[k-1];
        end
    end
    assign mul_y = stg[LAT-1];

    assign occ = dut.u_rfifo.wr_ptr - dut.u_rfifo.rd_ptr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Handshakes observed mid-cycle happen at the following rising edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid && out_ready) begin
                pop_q.push_back(out_y);
                pop_cyc.push_back(cyc);
            end
            chk("no_overflow", 64'(occ <= 4'(DEP)), 64'd1);
        end
    end

    initial begin
        // Reset
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mul_b", mul_b, 64'd0);
        chk("rst_mul_x", mul_x, 64'd0);

        // Single op
        in_b = 64'h0004_0003_0002_0001;
        in_x = 64'h0040_0030_0020_0010;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("single_mul_b", mul_b, 64'h0004_0003_0002_0001);
        chk("single_mul_x", mul_x, 64'h0040_0030_0020_0010);
        chk("single_busy", 64'(busy), 64'd1);
        repeat (LAT) tick;
        chk("single_early", 64'(out_valid), 64'd0);
        tick;
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_y", out_y, 64'h0044_0033_0022_0011);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("single_busy_done", 64'(busy), 64'd0);
        chk("single_drained", 64'(out_valid), 64'd0);

        // Streaming
        pop_q.delete();
        pop_cyc.delete();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_b = 64'(i);
            in_x = 64'd100;
            chk("stream_in_ready", 64'(in_ready), 64'd1);
            tick;
        end
        in_valid = 1'b0;
        w = 0;
        while (pop_q.size() < 20 && w < 50) begin
            tick;
            w++;
        end
        chk("stream_count", 64'(pop_q.size()), 64'd20);
        for (int i = 0; i < pop_q.size(); i++) begin
            chk("stream_y", pop_q[i], 64'(100 + i));
        end
        span = (pop_cyc.size() > 0) ? (pop_cyc[pop_cyc.size()-1] - pop_cyc[0]) : -1;
        chk("stream_rate", 64'(span), 64'd19);
        out_ready = 1'b0;
        chk("stream_idle", 64'(busy), 64'd0);

        // Backpressure
        pop_q.delete();
        acc_cnt  = 0;
        in_x     = '0;
        in_valid = 1'b1;
        repeat (20) begin
            in_b = 64'(200 + acc_cnt);
            tick;
        end
        chk("bp_accepts", 64'(acc_cnt), 64'd8);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_credit", 64'(dut.credit_cnt), 64'd8);
        chk("bp_buffered", 64'(occ), 64'd8);
        chk("bp_head", out_y, 64'd200);

        in_b = 64'(200 + acc_cnt);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("pulse_credit", 64'(dut.credit_cnt), 64'd7);
        chk("pulse_in_ready", 64'(in_ready), 64'd1);
        chk("pulse_no_accept", 64'(acc_cnt), 64'd8);
        tick;
        chk("pulse_one_accept", 64'(acc_cnt), 64'd9);
        chk("pulse_refull", 64'(dut.credit_cnt), 64'd8);
        chk("pulse_closed", 64'(in_ready), 64'd0);

        in_b = 64'(200 + acc_cnt);
        out_ready = 1'b1;
        tick;
        chk("full_pop_credit", 64'(dut.credit_cnt), 64'd7);
        tick;
        chk("acc_pop_credit", 64'(dut.credit_cnt), 64'd7);
        chk("acc_pop_accepts", 64'(acc_cnt), 64'd10);
        in_valid = 1'b0;
        w = 0;
        while (busy && w < 60) begin
            tick;
            w++;
        end
        out_ready = 1'b0;
        chk("bp_drain_busy", 64'(busy), 64'd0);
        chk("bp_pop_count", 64'(pop_q.size()), 64'd10);
        for (int i = 0; i < pop_q.size(); i++) begin
            chk("bp_order", pop_q[i], 64'(200 + i));
        end

        // Reset with 3 in flight and 2 buffered
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_b = 64'(300 + i);
            in_x = '0;
            tick;
        end
        in_valid = 1'b0;
        tick;
        tick;
        chk("mid_buffered", 64'(occ), 64'd2);
        chk("mid_credit", 64'(dut.credit_cnt), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        tick;
        tick;
        rst_n = 1'b1;
        seen_vld = 1'b0;
        repeat (10) begin
            tick;
            seen_vld = seen_vld | out_valid;
        end
        chk("mid_no_stale", 64'(seen_vld), 64'd0);

        in_b = 64'h1111_2222_3333_4444;
        in_x = 64'h0001_0001_0001_F000;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (LAT) tick;
        chk("fresh_early", 64'(out_valid), 64'd0);
        tick;
        chk("fresh_valid", 64'(out_valid), 64'd1);
        chk("fresh_y", out_y, 64'h1112_2223_3334_3444);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("fresh_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/quat_mul_issue.md
# quat_mul_issue

Issue/collect controller wrapped around the 4-stage pipelined quaternion multiplier. It accepts operand pairs (b, x) over a valid/ready interface and drives them into the multiplier. It tracks every in-flight operation with a tag shift register and captures the multiplier's outputs into a result FIFO. A credit counter sizes in-flight work to the FIFO, so a result is never dropped when the consumer stalls.

## Interface

- MUL_LATENCY, 4: clock edges from a value on mul_b/mul_x to the matching valid value on mul_y. Must match the multiplier.
- RDEPTH, 8: result FIFO depth. Power of two, ≥2. Must be ≥ MUL_LATENCY+2 for one-op-per-cycle throughput.

- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block will accept the pair this cycle.
- in_b  in  64  quaternion b as {b3,b2,b1,b0}, 16-bit signed lanes, b0 in [15:0].
- in_x  in  64  quaternion x, same packing.
- mul_b  out  64  registered b to the multiplier, same packing.
- mul_x  out  64  registered x to the multiplier.
- mul_y  in  64  multiplier result {y3,y2,y1,y0}.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  consumer takes the head result.
- out_y  out  64  head of the result FIFO, first-word-fall-through.
- busy  out  1  credit_cnt != 0, i.e. any operation in flight or buffered.

## Operation

- Accept: accept = in_valid && in_ready. On an accepting edge, in_b/in_x load into mul_b/mul_x. Without accept, mul_b/mul_x hold their last value.
- Tag pipe:
  - vld_sr[0..MUL_LATENCY]; vld_sr[0] <= accept and vld_sr[k] <= vld_sr[k-1].
  - vld_sr[MUL_LATENCY] high means mul_y holds a valid result this cycle.
- Capture: on an edge where vld_sr[MUL_LATENCY]=1, mul_y is written into the result FIFO at the write pointer.
- Pop: pop = out_valid && out_ready. It advances the read pointer.
- FIFO:
  - Pointers are log2(RDEPTH)+1 bits; wrap is natural.
  - empty when the pointers are equal.
  - Simultaneous write and pop are both honoured.
- Credits: credit_cnt, 0..RDEPTH, counts in-flight plus buffered operations.
  - +1 on accept, −1 on pop, unchanged when both occur.
  - in_ready = (credit_cnt < RDEPTH). It is combinational from the register only; out_ready has no combinational path to in_ready.
  - Consequence: a pop at full credit frees the slot from the next cycle.
- FIFO overflow is structurally impossible. The bench asserts it never happens; a write when full is a design error.
- Results leave in acceptance order. No reordering and no drops.
- Arithmetic: none in this block. Data passes bit-exact.

## Timing

- Reset (asynchronous assert, release synchronous to clk):
  - credit_cnt=0, so in_ready=1.
  - out_valid=0, busy=0.
  - mul_b=mul_x=0, vld_sr=0, FIFO pointers 0.
  - out_y is don't-care while out_valid=0.
- Latency: an accept at edge A puts operands on mul_b/mul_x after A. The multiplier samples them at A+1. mul_y is valid during the cycle after A+MUL_LATENCY. Capture happens at A+MUL_LATENCY+1, and out_valid rises after that edge (5+1=6 edges into the flow at defaults).
- Earliest pop is at A+MUL_LATENCY+2. The credit is visible in in_ready the cycle after the pop.
- Throughput: 1 op/cycle sustained when out_ready=1 and RDEPTH ≥ MUL_LATENCY+2.
- Reset mid-operation: all tags and buffered results are discarded. Stale values emerging from the multiplier's unreset pipeline must not be captured.
- out_valid/out_y stay stable while out_ready=0.

## Test plan

Bench stub: a MUL_LATENCY-edge delay computing each y lane as (b lane + x lane) mod 2^16.

- Reset: hold rst_n=0 then release → in_ready=1, out_valid=0, busy=0, mul_b=mul_x=0.
- Single op: accept b=0x0004_0003_0002_0001, x=0x0040_0030_0020_0010 at edge A → out_valid rises after A+5 with out_y=0x0044_0033_0022_0011. Pop at A+6 → busy=0 after A+6.
- Streaming: in_valid=1 and out_ready=1 for 20 ops with b0=i, x0=100 → 20 in-order results with y0=100+i. in_ready never drops. One result per cycle after the first.
- Backpressure: out_ready=0, in_valid=1 continuously → exactly 8 accepts, then in_ready=0 and out_valid=1 with 8 buffered. A one-cycle out_ready pulse → next cycle in_ready=1, exactly one more accept, no loss or duplication.
- Full-credit simultaneous event: credit_cnt=8, pop and (in_ready=0) in the same cycle → credit_cnt=7. The next accept+pop in the same cycle leaves it at 7.
- Reset mid-flight: assert rst_n=0 with 3 in flight and 2 buffered → out_valid stays 0 for 10 cycles after release even though the stub still emits values, and a fresh op then completes normally.
